// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-4 Booth sequential multiplier.
//   W      : default operand width (even), product width is 2*W
//   NDIG   : number of radix-4 Booth digits for the default width (W/2)
//   state_t: controller states (IDLE / RUN / DONE)
//   digit_t: recoded Booth digit in {-2,-1,0,+1,+2}
//   booth_digit(): maps a 3-bit Booth triplet {y[2i+1],y[2i],y[2i-1]} to a digit
// ---------------------------------------------------------------------------
package booth_pkg;

    localparam int W    = 12;
    localparam int NDIG = W / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_P1   = 3'd1,
        DIG_P2   = 3'd2,
        DIG_M1   = 3'd3,
        DIG_M2   = 3'd4
    } digit_t;

    function automatic digit_t booth_digit(input logic [2:0] triplet);
        digit_t d;
        case (triplet)
            3'b001, 3'b010: d = DIG_P1;
            3'b011:         d = DIG_P2;
            3'b100:         d = DIG_M2;
            3'b101, 3'b110: d = DIG_M1;
            default:        d = DIG_ZERO;   // 000 and 111
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// ---------------------------------------------------------------------------
// booth_pp_sel
// Combinational Booth partial-product selector.
// Ports:
//   triplet : {y[2i+1], y[2i], y[2i-1]} Booth triplet of the current digit
//   x       : signed multiplicand, W bits
//   pp      : signed partial product d*x, W+2 bits (wide enough for +/-2*x)
// ---------------------------------------------------------------------------
module booth_pp_sel
    import booth_pkg::*;
#(
    parameter int W = booth_pkg::W
) (
    input  logic [2:0]          triplet,
    input  logic [W-1:0]        x,
    output logic signed [W+1:0] pp
);

    logic signed [W+1:0] x_ext;
    digit_t              digit;

    assign x_ext = {{2{x[W-1]}}, x};
    assign digit = booth_digit(triplet);

    always_comb begin
        pp = '0;
        case (digit)
            DIG_P1:  pp = x_ext;
            DIG_P2:  pp = x_ext <<< 1;
            DIG_M1:  pp = -x_ext;
            DIG_M2:  pp = -(x_ext <<< 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// ---------------------------------------------------------------------------
// booth_seq_ctrl
// Sequential radix-4 Booth multiplier controller: one Booth digit per cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : operand pair x/y offered
//   in_ready   : controller accepts operands (IDLE and not in reset)
//   x, y       : signed W-bit multiplicand / multiplier
//   out_valid  : product holds a valid result (DONE state)
//   out_ready  : consumer takes the product
//   product    : signed 2*W-bit x*y, straight from the accumulator register
//   busy       : high whenever the controller is not IDLE
// Optional build macro:
//   BOOTH_EARLY_DONE_EN : finish as soon as every remaining Booth triplet is
//                         000 or 111 (latency i+1, minimum 1). Without it the
//                         latency is a fixed W/2 cycles. Product is identical.
// ---------------------------------------------------------------------------
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int W = booth_pkg::W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic             busy
);

    // Digit count follows the instance width; booth_pkg::NDIG is the default.
    localparam int ND = W / 2;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;

    state_t              state_reg, state_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [W-1:0]        x_reg, y_reg;
    logic [2*W-1:0]      acc_reg, acc_next;
    logic                load;

    logic [W:0]          y_ext;
    logic [2:0]          triplet;
    logic signed [W+1:0] pp;
    logic [2*W-1:0]      pp_ext;
    logic [2*W-1:0]      pp_shifted;
    logic                last_digit;

    // y[-1] = 0 is appended below the LSB, so triplet i sits at y_ext[2i+2:2i].
    assign y_ext   = {y_reg, 1'b0};
    assign triplet = y_ext[{idx_reg, 1'b0} +: 3];

    booth_pp_sel #(.W(W)) u_pp_sel (
        .triplet (triplet),
        .x       (x_reg),
        .pp      (pp)
    );

    // Size cast of a signed value sign-extends to the product width.
    assign pp_ext     = (2*W)'(pp);
    assign pp_shifted = pp_ext << {idx_reg, 1'b0};

`ifdef BOOTH_EARLY_DONE_EN
    // tail_uniform[gi]: all triplets above digit gi are 000/111, which holds
    // exactly when y[W-1:2*gi+1] is all zeros or all ones.
    logic [ND-1:0] tail_uniform;

    for (genvar gi = 0; gi < ND; gi++) begin : g_tail
        localparam int LO = 2*gi + 1;
        assign tail_uniform[gi] = (&y_reg[W-1:LO]) | ~(|y_reg[W-1:LO]);
    end

    assign last_digit = tail_uniform[idx_reg];
`else
    assign last_digit = (idx_reg == IW'(ND - 1));
`endif

    assign in_ready  = (state_reg == ST_IDLE) && !rst;
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign product   = acc_reg;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        acc_next   = acc_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    load       = 1'b1;
                    acc_next   = '0;
                    idx_next   = '0;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_next = acc_reg + pp_shifted;
                if (last_digit) begin
                    idx_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            ST_DONE: begin
                // Return to IDLE only; new operands are taken on a later edge.
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            acc_reg   <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            acc_reg   <= acc_next;
            if (load) begin
                x_reg <= x;
                y_reg <= y;
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_ctrl
// Scoreboard bench for booth_seq_ctrl (W=12). Accepted operand pairs push the
// expected product and latency (from plain signed arithmetic) into a queue;
// a monitor on the falling edge pops and compares when a product is taken.
// Define BOOTH_EARLY_DONE_EN for both bench and RTL to test the early-done build.
// ---------------------------------------------------------------------------
module tb_booth_seq_ctrl;

    localparam int W  = 12;
    localparam int ND = W / 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    x = '0;
    logic [W-1:0]    y = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  product;
    logic            busy;

    bit ready_rand  = 1'b0;
    bit ready_force = 1'b1;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int op_num = 0;

    typedef struct {
        logic [2*W-1:0] prod;
        int             lat;
        int             acc_edge;
    } exp_t;

    exp_t sb[$];
    bit   ov_prev = 1'b0;

    booth_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: signed product modulo 2^(2W).
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint pa, pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return (2*W)'(pa * pb);
    endfunction

    // Reference latency: W/2 cycles, or with early done the smallest k >= 1
    // such that y is representable as a 2k-bit signed number.
    function automatic int ref_lat(input logic [W-1:0] b);
`ifdef BOOTH_EARLY_DONE_EN
        longint v;
        v = longint'($signed(b));
        for (int k = 1; k < ND; k++) begin
            if (v >= -(longint'(1) <<< (2*k - 1)) && v < (longint'(1) <<< (2*k - 1)))
                return k;
        end
`endif
        return ND;
    endfunction

    // Monitor: records accepts, checks latency at out_valid rise and product on take.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_t e;
                e.prod     = ref_prod(x, y);
                e.lat      = ref_lat(y);
                e.acc_edge = cyc + 1;
                sb.push_back(e);
            end
            if (out_valid && !ov_prev) begin
                check("op_pending_at_out_valid", longint'(sb.size() > 0), 1);
                if (sb.size() > 0)
                    check("latency", cyc - sb[0].acc_edge, sb[0].lat);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                op_num++;
                $display("op %0d: product=%h expected=%h", op_num, product, e.prod);
                check("product", product, e.prod);
            end
            ov_prev = out_valid;
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(posedge clk);
        #1;
        x = a;
        y = b;
        in_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept_wait", longint'(n < 200), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble the inputs to show registered operands are held.
        x = W'($urandom);
        y = W'($urandom);
    endtask

    task automatic wait_out();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("out_valid_wait", longint'(n < 200), 1);
    endtask

    task automatic directed(input string name, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [2*W-1:0] exp);
        issue(a, b);
        wait_out();
        check(name, product, exp);
        @(posedge clk);
    endtask

    initial begin
        logic [2*W-1:0] cap;
        bit             seen;
        int             n;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Directed operands.
        directed("x1_y2", 12'd1, 12'd2, 24'd2);
        directed("min_min", 12'h800, 12'h800, 24'h400000);
        directed("max_min", 12'h7FF, 12'h800, 24'hC00800);
        directed("neg7_pos3", 12'hFF9, 12'd3, 24'hFFFFEB);

`ifdef BOOTH_EARLY_DONE_EN
        directed("early_y1", 12'hFF9, 12'd1, 24'hFFFFF9);
        directed("early_y0", 12'd5, 12'd0, 24'd0);
`endif

        // Backpressure in DONE: product held, new operands ignored.
        ready_force = 1'b0;
        issue(12'd100, 12'd37);
        wait_out();
        cap = product;
        check("bp_product", cap, 24'd3700);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        x = 12'd5;
        y = 12'd5;
        repeat (3) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_product_stable", product, cap);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ready_force = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("bp_release_idle", busy, 0);

        // Reset pulse while digit 3 is being processed.
        issue(12'd9, 12'd11);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrun_rst_no_out", seen, 0);
        check("midrun_rst_idle", in_ready, 1);
        directed("after_rst_3x5", 12'd3, 12'd5, 24'd15);

        // Randomized operands with random gaps and random out_ready.
        ready_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic [W-1:0] a, b;
            int sel;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            a = W'($urandom);
            b = W'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) a = 12'h800;
            if (sel == 1) b = 12'h7FF;
            if (sel == 2) b = W'($urandom_range(0, 3)) - 12'd2;
            issue(a, b);
        end
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("drain", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
